a2s_unpacker: RTL and testbench

Stream-side consumer of the A2S read buffer, clocked on Sclk. It issues buffer read enables (Oen) towards the A2S controller, captures the returned buffer words with one-cycle read latency, and serialises each word into narrower samples. Samples leave on a valid/ready interface towards the DAC/baseband path. `sync` realigns it together with the A2S controller.

---
 rtl/a2s_unpacker.sv | 98 +++++++++
 tb/tb_a2s_unpacker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2s_unpacker.sv
// a2s_unpacker: pulls A2S buffer words on Sclk and serialises each into SW-bit samples
// on a valid/ready stream; sync clears it in step with the A2S controller.
module a2s_unpacker #(
    parameter int DW = 64,
    parameter int SW = 16,
    localparam int LANES = DW / SW
) (
    input  logic          Sclk,
    input  logic          rst,
    input  logic          sync,
    input  logic          enable,
    output logic          Oen,
    input  logic [DW-1:0] buf_rdata,
    output logic [SW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   sample_cnt,
    output logic [31:0]   word_cnt
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;

    logic          r_oen, r_rdq, r_uvalid, r_wptr, r_rptr;
    logic [1:0]    r_fcount;
    logic [LW-1:0] r_lane;
    logic [DW-1:0] r_ureg;
    logic [DW-1:0] r_fifo [2];
    logic [SW-1:0] r_out_data;
    logic [31:0]   r_sample_cnt, r_word_cnt;

    logic          w_accept, w_last, w_ufree, w_bypass, w_push, w_pop, w_load;
    logic          w_oen_nxt, w_uvalid_nxt;
    logic [2:0]    w_busy;
    logic [LW-1:0] w_lane_nxt;
    logic [DW-1:0] w_ureg_nxt;

    assign w_accept     = r_uvalid & out_ready;
    assign w_last       = r_lane == LW'(LANES - 1);
    assign w_ufree      = ~r_uvalid | (w_accept & w_last);
    assign w_bypass     = r_rdq & (r_fcount == 2'd0) & w_ufree;
    assign w_push       = r_rdq & ~w_bypass;
    assign w_pop        = w_ufree & (r_fcount != 2'd0);
    assign w_load       = w_pop | w_bypass;
    // A pop in the same cycle is not credited, so reads can never overrun the FIFO.
    assign w_busy       = 3'(r_fcount) + 3'(r_oen) + 3'(r_rdq);
    assign w_oen_nxt    = enable & (w_busy < 3'd2);
    assign w_ureg_nxt   = w_pop ? r_fifo[r_rptr] : w_bypass ? buf_rdata : r_ureg;
    assign w_lane_nxt   = (w_load | (w_accept & w_last)) ? '0 : w_accept ? r_lane + LW'(1) : r_lane;
    assign w_uvalid_nxt = w_load | (r_uvalid & ~(w_accept & w_last));

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            r_oen        <= 1'b0;
            r_rdq        <= 1'b0;
            r_uvalid     <= 1'b0;
            r_lane       <= '0;
            r_ureg       <= '0;
            r_fcount     <= 2'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_out_data   <= '0;
            r_sample_cnt <= '0;
            r_word_cnt   <= '0;
        end else if (sync) begin
            r_oen        <= 1'b0;
            r_rdq        <= 1'b0;
            r_uvalid     <= 1'b0;
            r_lane       <= '0;
            r_fcount     <= 2'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_out_data   <= '0;
            r_sample_cnt <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_oen        <= w_oen_nxt;
            r_rdq        <= r_oen;
            r_uvalid     <= w_uvalid_nxt;
            r_lane       <= w_lane_nxt;
            r_ureg       <= w_ureg_nxt;
            r_fcount     <= r_fcount + 2'(w_push) - 2'(w_pop);
            r_wptr       <= r_wptr ^ w_push;
            r_rptr       <= r_rptr ^ w_pop;
            r_out_data   <= w_ureg_nxt[w_lane_nxt*SW +: SW];
            r_sample_cnt <= r_sample_cnt + 32'(w_accept);
            r_word_cnt   <= r_word_cnt + 32'(r_oen);
        end
    end

    always_ff @(posedge Sclk) begin
        if (w_push) r_fifo[r_wptr] <= buf_rdata;
    end

    assign Oen        = r_oen;
    assign out_data   = r_out_data;
    assign out_valid  = r_uvalid;
    assign sample_cnt = r_sample_cnt;
    assign word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_a2s_unpacker.sv
// tb_a2s_unpacker: randomized bench for a2s_unpacker; a sample-queue reference model
// plus a buffer responder predict every output cycle by cycle.
module tb_a2s_unpacker;
    logic        Sclk = 1'b0;
    logic        rst, sync, enable, out_ready;
    logic [63:0] buf_rdata;
    logic        Oen, out_valid;
    logic [15:0] out_data;
    logic [31:0] sample_cnt, word_cnt;

    a2s_unpacker dut (
        .Sclk(Sclk), .rst(rst), .sync(sync), .enable(enable), .Oen(Oen),
        .buf_rdata(buf_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sample_cnt(sample_cnt), .word_cnt(word_cnt)
    );

    always #5 Sclk = ~Sclk;

    int          nrun = 0, nfail = 0, rk = 0;
    bit          rand_data = 1'b0;
    logic [15:0] q[$];
    bit          exp_oen, exp_rdq;
    logic [31:0] sc, wc;
    logic [63:0] bw;

    function automatic logic [63:0] mkword(int k);
        if (rand_data) return {$urandom, $urandom};
        return {16'(k * 4 + 3), 16'(k * 4 + 2), 16'(k * 4 + 1), 16'(k * 4)};
    endfunction

    task automatic model_reset();
        q.delete();
        exp_oen = 1'b0;
        exp_rdq = 1'b0;
        sc = '0;
        wc = '0;
    endtask

    // Advances the model and the buffer responder across one rising edge; returns at the negedge.
    task automatic tick();
        int fc;
        bit acc, iss, nxt;
        fc  = (q.size() > 0) ? (q.size() - 1) / 4 : 0;
        acc = (q.size() > 0) && out_ready;
        iss = exp_oen;
        if (sync) begin
            model_reset();
        end else begin
            if (acc) begin
                void'(q.pop_front());
                sc = sc + 1;
            end
            if (exp_rdq) for (int l = 0; l < 4; l++) q.push_back(bw[l*16 +: 16]);
            wc = wc + 32'(exp_oen);
            nxt = enable && (fc + int'(exp_oen) + int'(exp_rdq) < 2);
            exp_rdq = exp_oen;
            exp_oen = nxt;
        end
        @(posedge Sclk);
        @(negedge Sclk);
        if (iss) begin
            bw = mkword(rk);
            rk++;
        end else begin
            bw = {$urandom, $urandom};
        end
        buf_rdata = bw;
    endtask

    task automatic test_reset();
        nrun++;
        if (Oen !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || sample_cnt !== 0 || word_cnt !== 0)
            begin nfail++; $display("FAIL reset_init: Oen=%b valid=%b data=%h sc=%0d wc=%0d, want all 0", Oen, out_valid, out_data, sample_cnt, word_cnt); end
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (12) tick();
        #2 rst = 1'b1;
        #1;
        nrun++;
        if (Oen !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0)
            begin nfail++; $display("FAIL reset_mid_outputs: Oen=%b valid=%b data=%h, want 0 0 0000", Oen, out_valid, out_data); end
        nrun++;
        if (sample_cnt !== 0 || word_cnt !== 0)
            begin nfail++; $display("FAIL reset_mid_counts: sc=%0d wc=%0d, want 0 0", sample_cnt, word_cnt); end
        @(negedge Sclk);
        rst = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (10) begin
            tick();
            nrun++;
            if (Oen !== 1'b0 || out_valid !== 1'b0)
                begin nfail++; $display("FAIL idle_disabled: Oen=%b valid=%b, want 0 0", Oen, out_valid); end
        end
    endtask

    task automatic test_startup();
        int k0 = rk;
        rand_data = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        tick();
        nrun++;
        if (Oen !== 1'b1 || out_valid !== 1'b0)
            begin nfail++; $display("FAIL startup_e0: Oen=%b valid=%b, want 1 0", Oen, out_valid); end
        tick();
        nrun++;
        if (out_valid !== 1'b0)
            begin nfail++; $display("FAIL startup_e1: valid=%b, want 0", out_valid); end
        tick();
        nrun++;
        if (out_valid !== 1'b1 || out_data !== 16'(k0 * 4))
            begin nfail++; $display("FAIL startup_e2: valid=%b data=%h, want 1 %h", out_valid, out_data, 16'(k0 * 4)); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        repeat (200) begin
            tick();
            nrun++;
            if (out_valid !== 1'b1)
                begin nfail++; $display("FAIL stream_gap: valid=%b, want 1", out_valid); end
            if (q.size() > 0) begin
                nrun++;
                if (out_data !== q[0])
                    begin nfail++; $display("FAIL stream_data: got %h, want %h", out_data, q[0]); end
            end
            nrun++;
            if (Oen !== exp_oen)
                begin nfail++; $display("FAIL stream_oen: got %b, want %b", Oen, exp_oen); end
            nrun++;
            if (sample_cnt !== sc || word_cnt !== wc)
                begin nfail++; $display("FAIL stream_counts: sc=%0d wc=%0d, want %0d %0d", sample_cnt, word_cnt, sc, wc); end
            nrun++;
            if (int'(word_cnt) * 4 - int'(sample_cnt) > 12)
                begin nfail++; $display("FAIL stream_storage: wc=%0d sc=%0d, want wc*4-sc <= 12", word_cnt, sample_cnt); end
        end
    endtask

    task automatic test_backpressure();
        int k0;
        logic [15:0] held;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        k0 = rk;
        out_ready = 1'b0;
        repeat (3) tick();
        held = out_data;
        nrun++;
        if (out_valid !== 1'b1 || held !== 16'(k0 * 4))
            begin nfail++; $display("FAIL bp_first: valid=%b data=%h, want 1 %h", out_valid, held, 16'(k0 * 4)); end
        repeat (17) begin
            tick();
            nrun++;
            if (out_data !== held || out_valid !== 1'b1)
                begin nfail++; $display("FAIL bp_hold: valid=%b data=%h, want 1 %h", out_valid, out_data, held); end
        end
        nrun++;
        if (word_cnt !== 32'd3 || Oen !== 1'b0)
            begin nfail++; $display("FAIL bp_words: wc=%0d Oen=%b, want 3 0", word_cnt, Oen); end
        out_ready = 1'b1;
        repeat (60) begin
            tick();
            nrun++;
            if (out_valid !== (q.size() > 0))
                begin nfail++; $display("FAIL bp_valid: got %b, want %b", out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                nrun++;
                if (out_data !== q[0])
                    begin nfail++; $display("FAIL bp_data: got %h, want %h", out_data, q[0]); end
            end
            nrun++;
            if (Oen !== exp_oen || sample_cnt !== sc || word_cnt !== wc)
                begin nfail++; $display("FAIL bp_state: Oen=%b sc=%0d wc=%0d, want %b %0d %0d", Oen, sample_cnt, word_cnt, exp_oen, sc, wc); end
        end
    endtask

    task automatic test_enable_drop();
        int expd, n = 0;
        bit found = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_oen && q.size() >= 4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        nrun++;
        if (!found)
            begin nfail++; $display("FAIL drop_setup: no read with stored data within 30 cycles, want one"); end
        expd = q.size() + 4 * (int'(exp_rdq) + int'(exp_oen));
        enable = 1'b0;
        tick();
        nrun++;
        if (Oen !== 1'b0)
            begin nfail++; $display("FAIL drop_oen: got %b, want 0", Oen); end
        out_ready = 1'b1;
        repeat (40) begin
            if (out_valid === 1'b1) begin
                n++;
                nrun++;
                if (q.size() == 0 || out_data !== q[0])
                    begin nfail++; $display("FAIL drop_data: got %h, want %h", out_data, q.size() > 0 ? q[0] : 16'hx); end
            end
            tick();
            nrun++;
            if (Oen !== 1'b0)
                begin nfail++; $display("FAIL drop_oen_hold: got %b, want 0", Oen); end
        end
        nrun++;
        if (n != expd || n < 8 || out_valid !== 1'b0)
            begin nfail++; $display("FAIL drop_drain: drained %0d valid=%b, want %0d (>=8) 0", n, out_valid, expd); end
    endtask

    task automatic test_sync();
        int k1;
        bit found = 1'b0;
        rand_data = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (q.size() % 4 == 2 && exp_rdq) begin
                found = 1'b1;
                break;
            end
            out_ready = 1'($urandom % 2);
            tick();
        end
        nrun++;
        if (!found)
            begin nfail++; $display("FAIL sync_setup: lane 2 with read in flight not reached, want reached"); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        k1 = rk;
        nrun++;
        if (out_valid !== 1'b0 || Oen !== 1'b0)
            begin nfail++; $display("FAIL sync_clear: valid=%b Oen=%b, want 0 0", out_valid, Oen); end
        nrun++;
        if (sample_cnt !== 0 || word_cnt !== 0)
            begin nfail++; $display("FAIL sync_counts: sc=%0d wc=%0d, want 0 0", sample_cnt, word_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
        nrun++;
        if (out_valid !== 1'b1 || out_data !== 16'(k1 * 4))
            begin nfail++; $display("FAIL sync_restart: valid=%b data=%h, want 1 %h", out_valid, out_data, 16'(k1 * 4)); end
    endtask

    task automatic test_random();
        rand_data = 1'b1;
        repeat (10000) begin
            enable = ($urandom % 10) != 0;
            out_ready = 1'($urandom % 2);
            tick();
            nrun++;
            if (out_valid !== (q.size() > 0))
                begin nfail++; $display("FAIL rand_valid: got %b, want %b", out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                nrun++;
                if (out_data !== q[0])
                    begin nfail++; $display("FAIL rand_data: got %h, want %h", out_data, q[0]); end
            end
            nrun++;
            if (Oen !== exp_oen || sample_cnt !== sc || word_cnt !== wc)
                begin nfail++; $display("FAIL rand_state: Oen=%b sc=%0d wc=%0d, want %b %0d %0d", Oen, sample_cnt, word_cnt, exp_oen, sc, wc); end
            nrun++;
            if (dut.r_fcount > 2'd2 || (Oen === 1'b1 && dut.r_fcount == 2'd2))
                begin nfail++; $display("FAIL rand_fifo: fcount=%0d Oen=%b, want fcount<=2 and no read when full", dut.r_fcount, Oen); end
        end
    endtask

    initial begin
        rst = 1'b1;
        sync = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        buf_rdata = '0;
        bw = '0;
        model_reset();
        repeat (3) @(negedge Sclk);
        rst = 1'b0;
        test_reset();
        test_startup();
        test_stream();
        test_backpressure();
        test_enable_drop();
        test_sync();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule
